// File: rtl/peripheral_7seg_scan.sv
// peripheral_7seg_scan: memory-mapped multiplexed 7-segment display driver.
// The CPU writes packed BCD digits into a shadow buffer; the shadow is copied
// into the displayed buffer only at a frame boundary, so a frame never tears.
// Features: leading-zero blanking, minus glyph, decimal point, PWM brightness.
module peripheral_7seg_scan #(
  parameter int CLK_FREQ       = 50000000,
  parameter int REFRESH_HZ     = 1000,
  parameter int NDIG           = 8,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic [31:0]     d_in,
  input  logic            cs,
  input  logic [4:0]      addr,
  input  logic            rd,
  input  logic            wr,
  output logic [31:0]     d_out,
  output logic [6:0]      seg,
  output logic            dp,
  output logic [NDIG-1:0] an
);

  localparam int P  = CLK_FREQ / (REFRESH_HZ * NDIG);
  localparam int PW = (P > 1) ? $clog2(P) : 1;
  localparam int DW = 4 * NDIG;
  localparam logic [PW-1:0] P_LAST    = PW'(P - 1);
  localparam logic [2:0]    SCAN_LAST = 3'(NDIG - 1);

  localparam logic [4:0] ADDR_DIGITS = 5'h00;
  localparam logic [4:0] ADDR_CTRL   = 5'h04;
  localparam logic [4:0] ADDR_BRIGHT = 5'h08;
  localparam logic [4:0] ADDR_STATUS = 5'h0C;

  // Inactive output levels; XOR-ing an active-high value with these yields the pin level.
  localparam logic [6:0]      SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic            DP_OFF  = SEG_ACTIVE_LOW;
  localparam logic [NDIG-1:0] AN_OFF  = {NDIG{SEG_ACTIVE_LOW}};

  logic [DW-1:0]   shadow_reg, active_reg;
  logic            pending_reg;
  logic            enable_reg, lzb_reg, dp_en_reg;
  logic [2:0]      dp_pos_reg;
  logic [3:0]      bright_reg;
  logic [PW-1:0]   presc_reg;
  logic [2:0]      scan_reg;
  logic [3:0]      pwm_reg;
  logic [15:0]     frame_reg;
  logic [31:0]     d_out_reg;
  logic [6:0]      seg_reg;
  logic            dp_reg;
  logic [NDIG-1:0] an_reg;

  logic [31:0]     rd_data_next;
  logic [6:0]      seg_next;
  logic            dp_next;
  logic [NDIG-1:0] an_next;

  logic            slot_end, frame_wrap;
  logic            wr_en, wr_digits;
  logic [3:0]      nib [NDIG];
  logic [NDIG-1:0] an_onehot;
  logic [NDIG-1:0] blank;
  logic [NDIG:1]   lz;

  assign slot_end   = (presc_reg == P_LAST);
  assign frame_wrap = slot_end && (scan_reg == SCAN_LAST);
  assign wr_en      = cs && wr;
  assign wr_digits  = wr_en && (addr == ADDR_DIGITS);

  // Per-digit nibble view of the displayed buffer and one-hot anode select.
  for (genvar gi = 0; gi < NDIG; gi++) begin : g_digit
    assign nib[gi]       = active_reg[gi*4 +: 4];
    assign an_onehot[gi] = (scan_reg == 3'(gi));
  end

  // lz[i]: digits NDIG-1 down to i are all zero; digit 0 is never blanked.
  assign lz[NDIG] = 1'b1;
  assign blank[0] = 1'b0;
  for (genvar gi = 1; gi < NDIG; gi++) begin : g_blank
    assign lz[gi]    = lz[gi+1] && (nib[gi] == 4'd0);
    assign blank[gi] = lzb_reg && lz[gi];
  end

  function automatic logic [6:0] glyph(input logic [3:0] v);
    case (v)
      4'h0: glyph = 7'h3F;
      4'h1: glyph = 7'h06;
      4'h2: glyph = 7'h5B;
      4'h3: glyph = 7'h4F;
      4'h4: glyph = 7'h66;
      4'h5: glyph = 7'h6D;
      4'h6: glyph = 7'h7D;
      4'h7: glyph = 7'h07;
      4'h8: glyph = 7'h7F;
      4'h9: glyph = 7'h6F;
      4'hA: glyph = 7'h40;
      default: glyph = 7'h00;
    endcase
  endfunction

  // Read-data mux for the register map; unmapped offsets return zero.
  always_comb begin
    rd_data_next = 32'd0;
    case (addr)
      ADDR_DIGITS: rd_data_next = 32'(shadow_reg);
      ADDR_CTRL:   rd_data_next = {20'd0, dp_en_reg, dp_pos_reg, 6'd0, lzb_reg, enable_reg};
      ADDR_BRIGHT: rd_data_next = {28'd0, bright_reg};
      ADDR_STATUS: rd_data_next = {frame_reg, 9'd0, scan_reg, 3'd0, pending_reg};
      default:     rd_data_next = 32'd0;
    endcase
  end

  // Bus registers, shadow/active double buffer and the registered read port.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      shadow_reg  <= '0;
      active_reg  <= '0;
      pending_reg <= 1'b0;
      enable_reg  <= 1'b1;
      lzb_reg     <= 1'b0;
      dp_pos_reg  <= 3'd0;
      dp_en_reg   <= 1'b0;
      bright_reg  <= 4'hF;
      d_out_reg   <= 32'd0;
    end else begin
      // A write on the boundary cycle still commits the previous shadow value.
      if (frame_wrap && pending_reg)
        active_reg <= shadow_reg;
      if (wr_digits) begin
        shadow_reg  <= d_in[DW-1:0];
        pending_reg <= 1'b1;
      end else if (frame_wrap) begin
        pending_reg <= 1'b0;
      end
      if (wr_en && (addr == ADDR_CTRL)) begin
        enable_reg <= d_in[0];
        lzb_reg    <= d_in[1];
        dp_pos_reg <= d_in[10:8];
        dp_en_reg  <= d_in[11];
      end
      if (wr_en && (addr == ADDR_BRIGHT))
        bright_reg <= d_in[3:0];
      if (cs && rd)
        d_out_reg <= rd_data_next;
    end
  end

  // Slot prescaler, scan index, PWM phase and frame counter.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      presc_reg <= '0;
      scan_reg  <= 3'd0;
      pwm_reg   <= 4'd0;
      frame_reg <= 16'd0;
    end else begin
      presc_reg <= slot_end ? '0 : presc_reg + 1'b1;
      if (slot_end)
        scan_reg <= frame_wrap ? 3'd0 : scan_reg + 3'd1;
      pwm_reg <= pwm_reg + 4'd1;
      if (frame_wrap)
        frame_reg <= frame_reg + 16'd1;
    end
  end

  // Active-high display value for the current slot, then mapped to pin polarity.
  always_comb begin
    seg_next = SEG_OFF;
    dp_next  = DP_OFF;
    an_next  = AN_OFF;
    if (enable_reg) begin
      seg_next = (blank[scan_reg] ? 7'h00 : glyph(nib[scan_reg])) ^ SEG_OFF;
      dp_next  = (dp_en_reg && (scan_reg == dp_pos_reg)) ^ DP_OFF;
      if (pwm_reg <= bright_reg)
        an_next = an_onehot ^ AN_OFF;
    end
  end

  // Output registers: pins are glitch-free and one cycle behind the scan state.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      seg_reg <= SEG_OFF;
      dp_reg  <= DP_OFF;
      an_reg  <= AN_OFF;
    end else begin
      seg_reg <= seg_next;
      dp_reg  <= dp_next;
      an_reg  <= an_next;
    end
  end

  assign d_out = d_out_reg;
  assign seg   = seg_reg;
  assign dp    = dp_reg;
  assign an    = an_reg;

endmodule

// File: doc/peripheral_7seg_scan.md
Name: peripheral_7seg_scan

Overview:
- Memory-mapped multiplexed 7-segment display driver on the CPU data bus, decoded at chip-select slot cs[6], base 0x0045_0000.
- Consumes the packed BCD results the calculator software reads back from the bin2bcd peripheral and drives the board's digit anodes and segments.
- Double-buffered, so digit updates never tear mid-frame.
- Supports leading-zero blanking, a minus glyph, a decimal point and PWM brightness.

Parameters:
CLK_FREQ, 50000000, clk frequency in Hz
REFRESH_HZ, 1000, full-frame refresh rate in Hz
NDIG, 8, number of digits (2..8)
SEG_ACTIVE_LOW, 1, 1 = seg/dp/an outputs active-low; 0 = active-high

Ports:
clk  in  1  system clock
resetn  in  1  reset; one clock, asynchronous, active-low
d_in  in  32  write data (mem_wdata)
cs  in  1  chip select
addr  in  5  byte address within block (mem_addr[4:0])
rd  in  1  read strobe
wr  in  1  write strobe (|mem_wmask)
d_out  out  32  read data, registered
seg  out  7  segments, bit0=a … bit6=g
dp  out  1  decimal point
an  out  NDIG  digit enables; an[0] = least significant digit

Behaviour:
- Register map (word offsets):
  - 0x00 DIGITS (RW): NDIG BCD nibbles; nibble i = digit i.
  - 0x04 CTRL (RW): bit0 enable (reset 1); bit1 lzb (reset 0); bits[10:8] dp_pos; bit11 dp_en (reset 0).
  - 0x08 BRIGHT (RW): bits[3:0] (reset 0xF).
  - 0x0C STATUS (RO): bit0 pending; bits[6:4] scan index; bits[31:16] frame count.
  - Unmapped offsets read 0; writes to them are ignored.
- Write: on a posedge with cs&wr, the addressed register takes d_in.
  - A DIGITS write goes to the shadow register and sets pending=1.
- Read: on a posedge with cs&rd, d_out <= addressed value; otherwise d_out holds. A DIGITS read returns the shadow register.
- Slot timing: P = CLK_FREQ/(REFRESH_HZ*NDIG) clock cycles per digit slot; P must be ≥1 (default 6250).
  - A prescaler counts 0..P-1.
  - At P-1, scan index advances and wraps from NDIG-1 to 0.
- Frame boundary (wrap NDIG-1→0): if pending, the active buffer <= shadow and pending clears. Frame count increments, wrapping at 0xFFFF.
- Boundary collision: a DIGITS write in the same cycle as the boundary commits the old shadow. The new value lands in shadow with pending=1 and commits at the next boundary.
- Glyphs, active-high codes:
  - 0:3F, 1:06, 2:5B, 3:4F, 4:66, 5:6D, 6:7D, 7:07, 8:7F, 9:6F.
  - 0xA = minus (40); 0xB..0xF = blank (00).
- Leading-zero blanking (lzb=1): zero digits from NDIG-1 downward, up to the first nonzero digit, are blanked. Digit 0 is never blanked.
- dp asserted only while the scan index = dp_pos and dp_en=1.
- PWM: a free-running 4-bit counter pwm increments every clk.
  - The current anode is active when pwm ≤ BRIGHT, giving duty (BRIGHT+1)/16.
  - BRIGHT=15 means continuously on.
  - seg/dp follow the current digit regardless of PWM.
- enable=0: all anodes, segments and dp inactive. Scanning and commits continue.
- Output registers: seg/dp/an are registered, one cycle after the scan index/pwm state. With SEG_ACTIVE_LOW=1 they are inverted.
- Reset (async, resetn=0), effective immediately without waiting for a clock edge:
  - an, seg, dp are inactive (active-low case: an=all 1s, seg=7F, dp=1).
  - d_out=0; shadow=active=0; pending=0.
  - Prescaler, scan index, pwm and frame count = 0.
  - CTRL=0x001; BRIGHT=0xF.
- Reset mid-frame discards any uncommitted shadow value.

Test Plan:
1. Common bench setup for all scenarios: CLK_FREQ=160000, REFRESH_HZ=1000, NDIG=8, so P=20.
2. Reset: assert resetn low between clock edges -> an=FF, seg=7F, dp=1 before the next edge. After release, reads return CTRL=0x1, BRIGHT=0xF, STATUS=0.
3. Write DIGITS=0x12345678 -> STATUS.pending=1 until the first wrap.
   - After the commit, while an[0]=0: seg=00 ('8').
   - While an[7]=0: seg=79 ('1').
   - Each anode is low for 20 consecutive cycles per 160-cycle frame.
4. Write DIGITS=0x00000405 with CTRL=0x3 -> an[7:3] slots show seg=7F. Digit 2: seg=19 ('4'). Digit 1: seg=40 ('0'). Digit 0: seg=12 ('5').
   - Then write DIGITS=0 -> only the digit-0 slot shows seg=40.
5. Write DIGITS=0xA0000001 with CTRL=0x0B01 -> digit 7 shows seg=3F (minus), and dp=0 only during the digit-3 slot.
6. BRIGHT=3 -> within each slot the active anode is low exactly 4 of every 16 cycles.
   - CTRL=0 -> an stays FF while STATUS.frame count still increments.
   - A DIGITS write landing on the wrap cycle commits only at the following wrap.
